// File: rtl/cnn_acc_pkg.sv
// ============================================================================
// Module      : cnn_acc_pkg
// Description : Shared definitions for the convolution accumulate/requantise
//               block: controller state encoding, default datapath widths
//               and the round-half-up constant used before the right shift.
// Options     : CNN_ACC_RELU_EN (used by cnn_acc_requant_sat) clamps
//               negative results to zero after saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_acc_pkg;

    localparam int DEF_PROD_W = 23;   // 9s x 14s product
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_KLEN   = 9;    // 3x3 kernel taps
    localparam int DEF_SHIFT  = 6;
    localparam int DEF_OUT_W  = 9;

    // Half an output LSB, added before truncating so the shift rounds half-up.
    localparam longint DEF_ROUND = longint'(1) << (DEF_SHIFT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } acc_state_e;

    function automatic longint round_const(input int shift);
        return longint'(1) << (shift - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_acc_requant_sat.sv
// ============================================================================
// Module      : cnn_acc_requant_sat
// Description : Combinational requantiser. Adds the rounding constant,
//               arithmetic-shifts right by SHIFT, saturates to the signed
//               OUT_W range and optionally applies ReLU.
// Ports       : acc_i  - signed accumulator value
//               data_o - signed requantised result
//               sat_o  - high when the shifted value was clamped
// Options     : CNN_ACC_RELU_EN - negative results forced to 0 after
//               saturation; sat_o is not affected by the ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_acc_requant_sat
    import cnn_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_W
)
(
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam logic signed [ACC_W:0] c_RND = (ACC_W+1)'(round_const(SHIFT));
    localparam logic signed [ACC_W:0] c_MAX = (ACC_W+1)'((longint'(1) << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] c_MIN = (ACC_W+1)'(-(longint'(1) << (OUT_W-1)));

    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W:0]   w_shift;
    logic signed [OUT_W-1:0] w_sat;

    always_comb begin
        w_sum   = (ACC_W+1)'(acc_i) + c_RND;
        w_shift = w_sum >>> SHIFT;
        w_sat   = w_shift[OUT_W-1:0];
        sat_o   = 1'b0;
        if (w_shift > c_MAX) begin
            w_sat = c_MAX[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (w_shift < c_MIN) begin
            w_sat = c_MIN[OUT_W-1:0];
            sat_o = 1'b1;
        end
`ifdef CNN_ACC_RELU_EN
        data_o = w_sat[OUT_W-1] ? '0 : w_sat;
`else
        data_o = w_sat;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/cnn_conv_acc_requant.sv
// ============================================================================
// Module      : cnn_conv_acc_requant
// Description : Accumulates KLEN signed products (plus a bias sampled with
//               tap 0) and emits one rounded, saturated OUT_W-bit result
//               per kernel window over a valid/ready output handshake.
// Ports       : ap_clk / ap_rst        - clock, async active-high reset
//               prod_data/valid/ready  - product input stream
//               bias_in                - bias, taken with the tap-0 product
//               out_data/sat/valid/ready - result output stream
// Options     : CNN_ACC_RELU_EN - ReLU after saturation (see requant_sat).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_conv_acc_requant
    import cnn_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int KLEN   = DEF_KLEN,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int OUT_W  = DEF_OUT_W
)
(
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [ACC_W-1:0]  bias_in,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int              TAP_W      = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam logic [TAP_W-1:0] c_LAST_TAP = TAP_W'(KLEN - 1);

    // The accumulator must hold KLEN worst-case products without wrapping.
    generate
        if (ACC_W < PROD_W + $clog2(KLEN) + 1) begin : g_width_chk
            $error("cnn_conv_acc_requant: ACC_W too small for PROD_W and KLEN");
        end
    endgenerate

    acc_state_e              state_q, state_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic                    w_accept;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic signed [OUT_W-1:0] w_rq_data;
    logic                    w_rq_sat;

    // Datapath: the requantiser sees the value the accumulator is about to
    // take, so the result can be registered on the last-tap accept itself.
    always_comb begin
        prod_ready = (state_q != S_OUT) || out_ready;
        w_accept   = prod_valid && prod_ready;
        w_last     = (tap_q == c_LAST_TAP);
        w_prod_ext = ACC_W'(prod_data);
        w_acc_sum  = (tap_q == '0) ? (bias_in + w_prod_ext) : (acc_q + w_prod_ext);
    end

    cnn_acc_requant_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_requant_sat (
        .acc_i  (w_acc_sum),
        .data_o (w_rq_data),
        .sat_o  (w_rq_sat)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            tap_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;

        if ((state_q == S_OUT) && out_ready) begin
            state_d = S_IDLE;
        end

        // In S_OUT an accept only happens alongside the output handshake, so
        // tap_q is 0 and the product correctly starts the next window.
        if (w_accept) begin
            acc_d = w_acc_sum;
            if (w_last) begin
                tap_d      = '0;
                state_d    = S_OUT;
                out_data_d = w_rq_data;
                out_sat_d  = w_rq_sat;
            end else begin
                tap_d   = tap_q + TAP_W'(1);
                state_d = S_ACCUM;
            end
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_conv_acc_requant.sv
// ============================================================================
// Module      : tb_cnn_conv_acc_requant
// Description : Self-checking bench for cnn_conv_acc_requant. A window-level
//               model (sum of products plus bias, floor-divided after adding
//               half an LSB, clamped) predicts every output; outputs are
//               compared each cycle on the falling edge. Directed windows
//               pin the model to hand-computed values; a random phase follows.
// Options     : CNN_ACC_RELU_EN changes the expected negative results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_conv_acc_requant;

    localparam int PROD_W = 23;
    localparam int ACC_W  = 32;
    localparam int KLEN   = 9;
    localparam int SHIFT  = 6;
    localparam int OUT_W  = 9;

    logic                     ap_clk = 1'b0;
    logic                     ap_rst;
    logic signed [PROD_W-1:0] prod_data;
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [ACC_W-1:0]  bias_in;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_sat;
    logic                     out_valid;
    logic                     out_ready;

    always #5 ap_clk = ~ap_clk;

    cnn_conv_acc_requant #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .KLEN   (KLEN),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .bias_in    (bias_in),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    typedef struct {
        int d;
        bit s;
    } res_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    res_t   exp_q[$];
    int     gcnt     = 0;
    longint gsum     = 0;

    function automatic res_t ref_requant(input longint acc);
        longint t, q, div, maxv, minv;
        res_t   r;
        div  = longint'(1) << SHIFT;
        maxv = (longint'(1) << (OUT_W - 1)) - 1;
        minv = -(longint'(1) << (OUT_W - 1));
        t    = acc + div / 2;
        q    = t / div;
        if ((t % div) != 0 && t < 0) q = q - 1;   // floor for negatives
        r.s = 1'b0;
        if (q > maxv) begin q = maxv; r.s = 1'b1; end
        if (q < minv) begin q = minv; r.s = 1'b1; end
`ifdef CNN_ACC_RELU_EN
        if (q < 0) q = 0;
`endif
        r.d = int'(q);
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint rnd_prod();
        if ($urandom_range(0, 3) == 0)
            return longint'($urandom_range(0, (1 << PROD_W) - 1)) - (longint'(1) << (PROD_W - 1));
        return longint'($urandom_range(0, 4000)) - 2000;
    endfunction

    function automatic longint rnd_bias();
        return longint'($urandom_range(0, 1 << 21)) - (longint'(1) << 20);
    endfunction

    // One clock: compare outputs against the model, drive inputs, check
    // prod_ready, advance the model for the coming rising edge.
    task automatic cycle(input bit pv, input longint pd, input longint bias, input bit ordy);
        bit have, take, hs;
        have = exp_q.size() > 0;
        check("out_valid", out_valid, have);
        if (have) begin
            check("out_data", out_data, exp_q[0].d);
            check("out_sat", out_sat, exp_q[0].s);
        end
        prod_valid = pv;
        prod_data  = PROD_W'(pd);
        bias_in    = ACC_W'(bias);
        out_ready  = ordy;
        #1;
        check("prod_ready", prod_ready, !have || ordy);
        take = pv && (!have || ordy);
        hs   = have && ordy;
        if (hs) void'(exp_q.pop_front());
        if (take) begin
            if (gcnt == 0) gsum = bias + pd;
            else           gsum = gsum + pd;
            gcnt++;
            if (gcnt == KLEN) begin
                exp_q.push_back(ref_requant(gsum));
                gcnt = 0;
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, rnd_prod(), rnd_bias(), ordy);
    endtask

    task automatic send_group(input longint bias, input longint val, input bit gaps);
        for (int i = 0; i < KLEN; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle(1'b0);
            cycle(1'b1, val, (i == 0) ? bias : rnd_bias(), 1'b0);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) idle(1'b1);
    endtask

    // Pins model and DUT to a hand-computed result while the output is held.
    task automatic pin(input string nm, input int d, input bit s);
        check({nm, "_model"}, (exp_q.size() > 0) ? longint'(exp_q[0].d) : -99999, d);
        check({nm, "_valid"}, out_valid, 1);
        check({nm, "_data"}, out_data, d);
        check({nm, "_sat"}, out_sat, s);
    endtask

    task automatic do_reset();
        #2 ap_rst = 1'b1;
        prod_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        gcnt = 0;
        exp_q.delete();
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1 check("rst_prod_ready", prod_ready, 1);
        @(negedge ap_clk);
    endtask

    initial begin
        int neg_exp;
        ap_rst     = 1'b1;
        prod_valid = 1'b0;
        prod_data  = '0;
        bias_in    = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge ap_clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_sat", out_sat, 0);
        ap_rst = 1'b0;
        #1 check("reset_prod_ready", prod_ready, 1);
        @(negedge ap_clk);

        // Nine products of 64: (576 + 32) >> 6 = 9
        send_group(0, 64, 1'b0);
        pin("p64", 9, 1'b0);
        drain();

        // Nine products of 8000: 1125 clamps to 255
        send_group(0, 8000, 1'b0);
        pin("p8000", 255, 1'b1);
        drain();

        // Nine products of -1000: floor(-8968 / 64) = -141
`ifdef CNN_ACC_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -141;
`endif
        send_group(0, -1000, 1'b0);
        pin("pneg", neg_exp, 1'b0);
        drain();

        // Back-pressure: output held, products refused, then the product
        // offered with the handshake becomes tap 0 of the next window.
        send_group(0, 64, 1'b0);
        repeat (5) cycle(1'b1, 50, 7, 1'b0);
        pin("hold", 9, 1'b0);
        cycle(1'b1, 64, 0, 1'b1);
        for (int i = 0; i < KLEN - 1; i++) cycle(1'b1, 64, rnd_bias(), 1'b0);
        pin("chain", 9, 1'b0);
        drain();

        // Reset mid-window discards the partial sum.
        for (int i = 0; i < 4; i++) cycle(1'b1, 64, (i == 0) ? 100 : 0, 1'b0);
        do_reset();
        send_group(0, 64, 1'b0);
        pin("after_rst", 9, 1'b0);
        drain();

        // Bias only: (320 + 32) >> 6 = 5, with and without valid gaps.
        send_group(320, 0, 1'b0);
        pin("bias", 5, 1'b0);
        drain();
        send_group(320, 0, 1'b1);
        pin("bias_gaps", 5, 1'b0);
        drain();

        // Random traffic on both interfaces.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cycle($urandom_range(0, 9) < 7, rnd_prod(), rnd_bias(), $urandom_range(0, 9) < 6);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cnn_conv_acc_requant.md
CNN_CONV_ACC_REQUANT -- requirements
Module: cnn_conv_acc_requant

Interface
REQ-001 SHALL have parameter PROD_W, default 23, signed product width from the upstream 9s x 14s multiplier.
REQ-002 SHALL have parameter ACC_W, default 32, signed accumulator width.
REQ-003 SHALL have parameter KLEN, default 9, products per output (3x3 kernel taps).
REQ-004 SHALL have parameter SHIFT, default 6, requantisation right-shift (>=1).
REQ-005 SHALL have parameter OUT_W, default 9, signed output activation width.
REQ-006 SHALL have port ap_clk, input, 1 bit: the single clock; all state on rising edge.
REQ-007 SHALL have port ap_rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port prod_data, input, PROD_W bits: signed product.
REQ-009 SHALL have port prod_valid, input, 1 bit: prod_data valid.
REQ-010 SHALL have port prod_ready, output, 1 bit: product accepted when prod_valid&&prod_ready.
REQ-011 SHALL have port bias_in, input, ACC_W bits: signed bias, sampled with tap-0 product.
REQ-012 SHALL have port out_data, output, OUT_W bits: signed requantised result.
REQ-013 SHALL have port out_sat, output, 1 bit: out_data was saturated.
REQ-014 SHALL have port out_valid, output, 1 bit: out_data/out_sat valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts when out_valid&&out_ready.

Function
REQ-016 SHALL implement states IDLE, ACCUM, OUT; IDLE->ACCUM on tap-0 accept; ACCUM->OUT on tap KLEN-1 accept; OUT->IDLE on output handshake.
REQ-017 SHALL sign-extend prod_data to ACC_W; tap 0: acc <= bias_in + prod; taps 1..KLEN-1: acc <= acc + prod.
REQ-018 SHALL hold a tap counter 0..KLEN-1, incremented per accepted product, returning to 0 after tap KLEN-1.
REQ-019 SHALL compute the result as (acc + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT, i.e. round-half-up.
REQ-020 SHALL saturate the shifted value to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 iff clamped.
REQ-021 SHALL register out_data/out_sat and assert out_valid the cycle after the tap-(KLEN-1) accept (latency 1).
REQ-022 SHALL hold out_data, out_sat, out_valid stable while out_valid && !out_ready.
REQ-023 SHALL drive prod_ready = 1 in IDLE/ACCUM; in OUT, prod_ready = out_ready.
REQ-024 SHALL, on a simultaneous output handshake and product accept in OUT, treat the product as tap 0 of the next output (go to ACCUM, or OUT if KLEN==1).
REQ-025 SHALL ignore prod_data and bias_in when not accepted.

Reset
REQ-026 SHALL, on ap_rst asserted asynchronously, force state IDLE, tap counter 0, acc 0, out_data 0, out_sat 0, out_valid 0; prod_ready 1 after release.
REQ-027 SHALL discard any partial accumulation on reset mid-operation; next accepted product is tap 0.

Configuration
REQ-028 SHALL, with CNN_ACC_RELU_EN defined, clamp negative results to 0 after saturation (out_sat unaffected by ReLU); without it, output signed saturated values.

Structure
REQ-029 SHALL place state enum, default widths and the rounding constant in shared package cnn_acc_pkg.
REQ-030 SHALL implement round/shift/saturate/ReLU as combinational sub-module cnn_acc_requant_sat.
REQ-031 SHALL check at elaboration ACC_W >= PROD_W + clog2(KLEN) + 1 and report an error otherwise.

Verification
REQ-032 SHALL cover: bias 0, nine products of 64 -> out_data 9, out_sat 0, out_valid one cycle after ninth accept.
REQ-033 SHALL cover: bias 0, nine products of 8000 -> out_data 255, out_sat 1.
REQ-034 SHALL cover: bias 0, nine products of -1000 -> out_data -141 without CNN_ACC_RELU_EN, 0 with it; out_sat 0.
REQ-035 SHALL cover: out_ready low 5 cycles with out_valid high -> out_data stable, prod_ready 0; out_ready high with prod_valid high -> product taken as next tap 0.
REQ-036 SHALL cover: ap_rst asserted after 4 products of 64 (bias 100), then nine products of 64 with bias 0 -> out_data 9.
REQ-037 SHALL cover: bias 320, nine products of 0 -> out_data 5 (rounding of 5.0 exact), random prod_valid gaps -> identical result.
